md_unit: RTL

//  Multiply/divide unit of the E stage. Consumes MDU_op decoded for the E-stage instruction.

---
 rtl/md_unit.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- E-stage multiply/divide unit.
//
// Owns the HI/LO registers. mult/multu/div/divu compute their 64-bit result in
// the cycle they are accepted. The result is parked in a holding register, and
// the unit then stays busy for a fixed number of cycles before it commits that
// result to HI/LO. This models the latency of a multi-cycle multiplier/divider
// that the pipeline hazard logic has to respect.
//
// Ports
//   clk     in   1   system clock, rising edge
//   reset   in   1   synchronous, active-low reset
//   MDU_op  in   5   decoded md-class op for the E-stage instruction
//   A       in  32   forwarded rs value (multiplicand / dividend / mt data)
//   B       in  32   forwarded rt value (multiplier / divisor)
//   req     in   1   exception/interrupt taken; blocks new starts and mt writes
//   start   out  1   combinational: mult/multu/div/divu accepted this cycle
//   busy    out  1   registered: an operation is in flight
//   HI      out 32   HI register
//   LO      out 32   LO register
//   out     out 32   combinational: HI for mfhi, LO for mflo, otherwise 0
// -----------------------------------------------------------------------------
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  // Op encoding shared with the decoder. Any other code behaves like MDU_ERR.
  localparam logic [4:0] MDU_ERR   = 5'd0;
  localparam logic [4:0] MDU_MULT  = 5'd1;
  localparam logic [4:0] MDU_MULTU = 5'd2;
  localparam logic [4:0] MDU_DIV   = 5'd3;
  localparam logic [4:0] MDU_DIVU  = 5'd4;
  localparam logic [4:0] MDU_MTHI  = 5'd5;
  localparam logic [4:0] MDU_MTLO  = 5'd6;
  localparam logic [4:0] MDU_MFHI  = 5'd7;
  localparam logic [4:0] MDU_MFLO  = 5'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  // ---------------------------------------------------------------------------
  // Op decode
  // ---------------------------------------------------------------------------
  logic is_mul;
  logic is_div;
  logic mul_signed;
  logic div_signed;
  logic is_mthi;
  logic is_mtlo;
  logic is_mfhi;
  logic is_mflo;

  // NOTE: every signal written in a combinational block gets a default at the
  // top of the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    is_mul     = 1'b0;
    is_div     = 1'b0;
    mul_signed = 1'b0;
    div_signed = 1'b0;
    is_mthi    = 1'b0;
    is_mtlo    = 1'b0;
    is_mfhi    = 1'b0;
    is_mflo    = 1'b0;
    case (MDU_op)
      MDU_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
      MDU_MULTU: is_mul = 1'b1;
      MDU_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
      MDU_DIVU:  is_div = 1'b1;
      MDU_MTHI:  is_mthi = 1'b1;
      MDU_MTLO:  is_mtlo = 1'b1;
      MDU_MFHI:  is_mfhi = 1'b1;
      MDU_MFLO:  is_mflo = 1'b1;
      MDU_ERR:   ;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated in the accepting cycle
  // ---------------------------------------------------------------------------
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_prod;

  // Sign- or zero-extend to 64 bits, then multiply unsigned: the low 64 bits
  // of the product of the sign-extended operands equal the signed product.
  assign mul_a    = mul_signed ? {{32{A[31]}}, A} : {32'd0, A};
  assign mul_b    = mul_signed ? {{32{B[31]}}, B} : {32'd0, B};
  assign mul_prod = mul_a * mul_b;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_by_zero;
  logic [31:0] divisor;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;

  // Signed division runs on magnitudes. The quotient is negated when the
  // operand signs differ, which gives truncation toward zero. The remainder
  // follows the dividend's sign. 0x80000000 / -1 comes out as magnitude
  // 0x80000000 with equal signs, so LO=0x80000000 and HI=0 without a special
  // case.
  assign a_neg       = div_signed & A[31];
  assign b_neg       = div_signed & B[31];
  assign mag_a       = a_neg ? (32'd0 - A) : A;
  assign mag_b       = b_neg ? (32'd0 - B) : B;
  assign div_by_zero = (B == 32'd0);
  // A zero divisor is replaced so that the divider never sees /0. The result is
  // discarded anyway because res_wr stays low.
  assign divisor     = div_by_zero ? 32'd1 : mag_b;
  assign uquot       = mag_a / divisor;
  assign urem        = mag_a % divisor;
  assign quot        = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
  assign rem         = a_neg ? (32'd0 - urem) : urem;

  logic [63:0] result_d;
  logic        res_wr_d;

  assign result_d = is_div ? {rem, quot} : mul_prod;
  assign res_wr_d = is_mul | ~div_by_zero;

  // ---------------------------------------------------------------------------
  // Control FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done;
  logic             idle_ok;
  logic             res_wr_q;
  logic [63:0]      res_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      hi_d;
  logic [31:0]      lo_d;

  // A new op is accepted only when the unit is idle and no exception is taken.
  // A start while busy is ignored and does not restart the operation.
  assign idle_ok = (state_q == S_IDLE) & ~req;
  assign start   = (is_mul | is_div) & idle_ok;
  assign busy    = (state_q == S_BUSY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The cycle in which the counter shows 1 is the last busy cycle. The
        // result commits at its closing edge.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // HI/LO write selection. A commit can happen only in BUSY and an mt write
  // only in IDLE, so the two never collide.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (done && res_wr_q) begin
      {hi_d, lo_d} = res_q;
    end else if (idle_ok) begin
      if (is_mthi) hi_d = A;
      if (is_mtlo) lo_d = A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      res_wr_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (start) res_wr_q <= res_wr_d;
    end
  end

  // NOTE: the 64-bit result holder is deliberately left out of reset. It is
  // read only on a commit, which requires a start after reset, and that start
  // has loaded it. Only the control bits around it need a defined reset value.
  always_ff @(posedge clk) begin
    if (start) res_q <= result_d;
  end

  assign HI = hi_q;
  assign LO = lo_q;

  // ---------------------------------------------------------------------------
  // mfhi/mflo read port
  // ---------------------------------------------------------------------------
  always_comb begin
    out = 32'd0;
    if (is_mfhi)      out = hi_q;
    else if (is_mflo) out = lo_q;
  end

endmodule
